call_ret_ctrl: RTL and testbench

Program-counter sequencer that drives the push/pop side of the 16-entry return-address stack. It advances the PC, performs jumps, and converts call/return requests into single-cycle push/pop strobes toward the stack. It loads the return address the stack supplies, which is the stored value + 1. It sits between instruction decode and the stack, and is the stack's only master.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/callret_depth.sv | 40 ++++
 rtl/call_ret_ctrl.sv | 109 ++++++++++
 tb/tb_call_ret_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, reset PC and sequencer state encoding for the call/return path.
package cpu_pkg;

    localparam int PC_W        = 10;
    localparam int STACK_DEPTH = 16;
    localparam int DEPTH_W     = 5;

    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        CALL_PUSH = 3'd1,
        RET_POP   = 3'd2,
        RET_LOAD  = 3'd3,
        FAULT     = 3'd4
    } state_e;

endpackage

// File: rtl/callret_depth.sv
// Outstanding-call counter with full/empty compares; only built when
// CALLRET_DEPTH_CHECK_EN is defined.
module callret_depth
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    // Saturating so a stray strobe can never wrap the count.
    always_comb begin
        depth_d = depth_q;
        if (inc_i && !dec_i && !full_o) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (dec_i && !inc_i && !empty_o) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign depth_o = depth_q;
    assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign empty_o = (depth_q == '0);

endmodule

// File: rtl/call_ret_ctrl.sv
// PC sequencer driving push/pop strobes of the return-address stack.
// Depth tracking and the FAULT state exist only with CALLRET_DEPTH_CHECK_EN.
module call_ret_ctrl
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               call,
    input  logic               ret,
    input  logic               jump,
    input  logic [PC_W-1:0]    target,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [PC_W-1:0]    stk_data_out,
    input  logic [PC_W-1:0]    stk_data_in,
    output logic [DEPTH_W-1:0] depth,
    output logic               fault
);

    state_e            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   tgt_q;
    logic [PC_W-1:0]   push_data_q;
    logic              depth_full;
    logic              depth_empty;

`ifdef CALLRET_DEPTH_CHECK_EN
    logic depth_inc;
    logic depth_dec;

    // Count moves on the edge that completes each push or load.
    assign depth_inc = (state_q == CALL_PUSH);
    assign depth_dec = (state_q == RET_LOAD);

    callret_depth u_depth (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (depth_inc),
        .dec_i   (depth_dec),
        .depth_o (depth),
        .full_o  (depth_full),
        .empty_o (depth_empty)
    );
`else
    assign depth       = '0;
    assign depth_full  = 1'b0;
    assign depth_empty = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            tgt_q       <= '0;
            push_data_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        if (call) begin
                            if (depth_full) begin
                                state_q <= FAULT;
                            end else begin
                                state_q     <= CALL_PUSH;
                                tgt_q       <= target;
                                push_data_q <= pc_q;
                            end
                        end else if (ret) begin
                            state_q <= depth_empty ? FAULT : RET_POP;
                        end else if (jump) begin
                            pc_q <= target;
                        end else begin
                            pc_q <= pc_q + PC_W'(1);
                        end
                    end
                end
                CALL_PUSH: begin
                    pc_q    <= tgt_q;
                    state_q <= RUN;
                end
                RET_POP: begin
                    state_q <= RET_LOAD;
                end
                RET_LOAD: begin
                    // Stack presents pop data the cycle after the strobe.
                    pc_q    <= stk_data_in;
                    state_q <= RUN;
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign stk_data_out = push_data_q;
    assign stk_push     = (state_q == CALL_PUSH);
    assign stk_pop      = (state_q == RET_POP);
    assign busy         = (state_q != RUN);
    assign fault        = (state_q == FAULT);

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Bench for call_ret_ctrl: directed scenarios plus randomized ops against a
// transaction-level model (PC value + queue of pushed return addresses).
module tb_call_ret_ctrl;
    import cpu_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               en, call, ret, jump;
    logic [PC_W-1:0]    target;
    logic [PC_W-1:0]    pc;
    logic               busy, stk_push, stk_pop, fault;
    logic [PC_W-1:0]    stk_data_out;
    logic [PC_W-1:0]    stk_data_in;
    logic [DEPTH_W-1:0] depth;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef CALLRET_DEPTH_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic [PC_W-1:0] ref_pc;
    logic [PC_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    call_ret_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .call         (call),
        .ret          (ret),
        .jump         (jump),
        .target       (target),
        .pc           (pc),
        .busy         (busy),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_out (stk_data_out),
        .stk_data_in  (stk_data_in),
        .depth        (depth),
        .fault        (fault)
    );

    // Return-address stack: stores pushed PC, returns stored value + 1.
    logic [PC_W-1:0] stk_mem [16];
    logic [3:0]      sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp          <= 4'd0;
            stk_data_in <= '0;
        end else if (stk_push) begin
            stk_mem[sp] <= stk_data_out;
            sp          <= sp + 4'd1;
        end else if (stk_pop) begin
            stk_data_in <= stk_mem[sp - 4'd1] + PC_W'(1);
            sp          <= sp - 4'd1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_req();
        call = 1'b0; ret = 1'b0; jump = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; en = 1'b0; clear_req(); target = '0;
        tick(); tick();
        reset = 1'b0;
        ref_pc = RESET_PC;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; clear_req(); target = '0;
        tick();
        n_checks++; if (pc !== 10'h000) begin n_fail++; $display("FAIL reset_pc got %h exp 000", pc); end
        n_checks++; if ({busy, stk_push, stk_pop, fault} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {busy, stk_push, stk_pop, fault}); end
        n_checks++; if (stk_data_out !== 10'h000) begin n_fail++; $display("FAIL reset_data got %h exp 000", stk_data_out); end
        n_checks++; if (depth !== 5'd0) begin n_fail++; $display("FAIL reset_depth got %0d exp 0", depth); end
        reset = 1'b0;
        ref_pc = RESET_PC;
        exp_q.delete();
    endtask

    task automatic test_increment();
        en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_checks++; if (pc !== PC_W'(i)) begin n_fail++; $display("FAIL inc_pc got %h exp %h", pc, PC_W'(i)); end
            n_checks++; if ({stk_push, stk_pop} !== 2'b00) begin n_fail++; $display("FAIL inc_strobe got %b exp 00", {stk_push, stk_pop}); end
        end
    endtask

    task automatic test_call_ret();
        tick(); tick();
        n_checks++; if (pc !== 10'h007) begin n_fail++; $display("FAIL pre_call_pc got %h exp 007", pc); end
        call = 1'b1; target = 10'h100;
        tick(); clear_req();
        n_checks++; if ({stk_push, stk_pop, busy} !== 3'b101) begin n_fail++; $display("FAIL call_strobe got %b exp 101", {stk_push, stk_pop, busy}); end
        n_checks++; if (stk_data_out !== 10'h007) begin n_fail++; $display("FAIL call_data got %h exp 007", stk_data_out); end
        n_checks++; if (pc !== 10'h007) begin n_fail++; $display("FAIL call_hold_pc got %h exp 007", pc); end
        tick();
        n_checks++; if (pc !== 10'h100) begin n_fail++; $display("FAIL call_pc got %h exp 100", pc); end
        n_checks++; if (depth !== (CHK_EN ? 5'd1 : 5'd0)) begin n_fail++; $display("FAIL call_depth got %0d", depth); end
        n_checks++; if ({stk_push, busy} !== 2'b00) begin n_fail++; $display("FAIL call_done got %b exp 00", {stk_push, busy}); end
        ret = 1'b1;
        tick(); clear_req();
        n_checks++; if ({stk_pop, stk_push, busy} !== 3'b101) begin n_fail++; $display("FAIL ret_pop got %b exp 101", {stk_pop, stk_push, busy}); end
        tick();
        n_checks++; if ({stk_pop, busy} !== 2'b01) begin n_fail++; $display("FAIL ret_load got %b exp 01", {stk_pop, busy}); end
        tick();
        en = 1'b0;
        n_checks++; if (pc !== 10'h008) begin n_fail++; $display("FAIL ret_pc got %h exp 008", pc); end
        n_checks++; if (depth !== 5'd0) begin n_fail++; $display("FAIL ret_depth got %0d exp 0", depth); end
        n_checks++; if (stk_data_out !== 10'h007) begin n_fail++; $display("FAIL data_hold got %h exp 007", stk_data_out); end
    endtask

    task automatic test_priority();
        apply_reset();
        en = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (pc !== 10'h003) begin n_fail++; $display("FAIL prio_start got %h exp 003", pc); end
        call = 1'b1; ret = 1'b1; jump = 1'b1; target = 10'h020;
        tick(); clear_req(); en = 1'b0;
        n_checks++; if ({stk_push, stk_pop} !== 2'b10) begin n_fail++; $display("FAIL prio_strobe got %b exp 10", {stk_push, stk_pop}); end
        n_checks++; if (pc !== 10'h003) begin n_fail++; $display("FAIL prio_nojump got %h exp 003", pc); end
        tick();
        n_checks++; if (pc !== 10'h020) begin n_fail++; $display("FAIL prio_pc got %h exp 020", pc); end
        n_checks++; if ({stk_pop, busy} !== 2'b00) begin n_fail++; $display("FAIL prio_nopop got %b exp 00", {stk_pop, busy}); end
        tick();
        n_checks++; if ({stk_pop, busy} !== 2'b00) begin n_fail++; $display("FAIL prio_dropped got %b exp 00", {stk_pop, busy}); end
    endtask

    task automatic test_en_jump_wrap();
        en = 1'b0; call = 1'b1; ret = 1'b1; jump = 1'b1; target = 10'h155;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({pc, stk_push, stk_pop, busy} !== {10'h020, 3'b000}) begin n_fail++; $display("FAIL en_low got pc %h flags %b", pc, {stk_push, stk_pop, busy}); end
        end
        clear_req(); en = 1'b1; jump = 1'b1; target = 10'h3ff;
        tick(); clear_req();
        n_checks++; if (pc !== 10'h3ff) begin n_fail++; $display("FAIL jump_pc got %h exp 3ff", pc); end
        tick(); en = 1'b0;
        n_checks++; if (pc !== 10'h000) begin n_fail++; $display("FAIL wrap_pc got %h exp 000", pc); end
    endtask

    task automatic test_random();
        int kind;
        logic [PC_W-1:0] tgt;
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 4));
            tgt  = PC_W'($urandom);
            if (kind == 2 && exp_q.size() >= STACK_DEPTH) kind = 0;
            if (kind == 3 && exp_q.size() == 0) kind = 0;
            clear_req(); target = tgt; en = 1'b1;
            case (kind)
                0: ;
                1: jump = 1'b1;
                2: begin call = 1'b1; ret = 1'($urandom); jump = 1'($urandom); end
                3: begin ret = 1'b1; jump = 1'($urandom); end
                default: begin en = 1'b0; call = 1'($urandom); ret = 1'($urandom); jump = 1'($urandom); end
            endcase
            tick(); clear_req(); en = 1'($urandom);
            if (kind == 0) ref_pc = ref_pc + PC_W'(1);
            if (kind == 1) ref_pc = tgt;
            if (kind == 2) begin
                n_checks++; if ({stk_push, stk_pop} !== 2'b10 || stk_data_out !== ref_pc) begin n_fail++; $display("FAIL rnd_push got %b data %h exp 10 data %h", {stk_push, stk_pop}, stk_data_out, ref_pc); end
                tick();
                exp_q.push_back(ref_pc);
                ref_pc = tgt;
            end
            if (kind == 3) begin
                n_checks++; if ({stk_push, stk_pop} !== 2'b01) begin n_fail++; $display("FAIL rnd_pop got %b exp 01", {stk_push, stk_pop}); end
                tick();
                n_checks++; if ({stk_push, stk_pop, busy} !== 3'b001) begin n_fail++; $display("FAIL rnd_load got %b exp 001", {stk_push, stk_pop, busy}); end
                tick();
                ref_pc = exp_q.pop_back() + PC_W'(1);
            end
            n_checks++; if (pc !== ref_pc || busy !== 1'b0) begin n_fail++; $display("FAIL rnd_pc op %0d got %h busy %b exp %h", kind, pc, busy, ref_pc); end
            n_checks++; if (depth !== (CHK_EN ? DEPTH_W'(exp_q.size()) : 5'd0) || fault !== 1'b0) begin n_fail++; $display("FAIL rnd_depth got %0d fault %b exp %0d", depth, fault, exp_q.size()); end
        end
        en = 1'b0;
    endtask

`ifdef CALLRET_DEPTH_CHECK_EN
    task automatic test_fault();
        logic [PC_W-1:0] frozen;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            call = 1'b1; target = PC_W'(i * 8 + 1);
            tick(); clear_req(); tick();
        end
        n_checks++; if (depth !== 5'd16 || fault !== 1'b0) begin n_fail++; $display("FAIL full_depth got %0d fault %b exp 16 0", depth, fault); end
        frozen = pc;
        call = 1'b1; target = 10'h2aa;
        tick(); clear_req();
        n_checks++; if ({stk_push, fault, busy} !== 3'b011) begin n_fail++; $display("FAIL ovf got %b exp 011", {stk_push, fault, busy}); end
        for (int i = 0; i < 4; i++) begin
            en = 1'($urandom); call = 1'($urandom); ret = 1'($urandom); jump = 1'($urandom);
            tick();
            n_checks++; if (pc !== frozen || {stk_push, stk_pop, fault} !== 3'b001) begin n_fail++; $display("FAIL ovf_hold got pc %h flags %b exp %h 001", pc, {stk_push, stk_pop, fault}, frozen); end
        end
        apply_reset();
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear got %b exp 0", fault); end
        en = 1'b1; ret = 1'b1;
        tick(); clear_req();
        n_checks++; if ({stk_pop, fault, busy} !== 3'b011) begin n_fail++; $display("FAIL udf got %b exp 011", {stk_pop, fault, busy}); end
        tick();
        n_checks++; if (pc !== 10'h000 || stk_pop !== 1'b0) begin n_fail++; $display("FAIL udf_hold got pc %h pop %b", pc, stk_pop); end
        apply_reset();
    endtask
`endif

    task automatic test_reset_mid();
        apply_reset();
        en = 1'b1; call = 1'b1; target = 10'h055;
        tick(); clear_req(); tick();
        ret = 1'b1;
        tick(); clear_req(); en = 1'b0;
        n_checks++; if (stk_pop !== 1'b1) begin n_fail++; $display("FAIL mid_in_pop got %b exp 1", stk_pop); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if ({pc, stk_data_out} !== 20'h0) begin n_fail++; $display("FAIL mid_async got pc %h data %h exp 0", pc, stk_data_out); end
        n_checks++; if ({busy, stk_push, stk_pop, fault, depth} !== 9'h0) begin n_fail++; $display("FAIL mid_flags got %b exp 0", {busy, stk_push, stk_pop, fault, depth}); end
        reset = 1'b0;
        tick();
        n_checks++; if ({stk_pop, busy} !== 2'b00 || pc !== 10'h000) begin n_fail++; $display("FAIL mid_after got pop/busy %b pc %h", {stk_pop, busy}, pc); end
        tick();
        n_checks++; if ({stk_pop, stk_push} !== 2'b00) begin n_fail++; $display("FAIL mid_quiet got %b exp 00", {stk_pop, stk_push}); end
    endtask

    initial begin
        test_reset();
        test_increment();
        test_call_ret();
        test_priority();
        test_en_jump_wrap();
        test_random();
`ifdef CALLRET_DEPTH_CHECK_EN
        test_fault();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
